muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Sequencer for the shared combinational multiplier in the EX stage. It accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO operations from the pipeline and owns the architectural HI/LO registers. It runs each multiply over a fixed multi-cycle window, drives the multiplier's operand inputs, and applies sign correction to its unsigned product. It raises a stall to the hazard unit whenever a request cannot be accepted.

## Interface
- DATA_WIDTH, 32, operand/HI/LO width
- MULT_LATENCY, 4, cycles from accept to HI/LO update (legal range 1..15)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation request from EX
- op_code  in  3  000 MULT, 001 MULTU, 010 MFHI, 011 MFLO, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
- op_a, op_b  in  DATA_WIDTH  rs/rt operands (op_a is the MTHI/MTLO source)
- flush  in  1  pipeline flush; aborts any in-flight multiply
- mul_in1, mul_in2  out  DATA_WIDTH  operand magnitudes to multiplier
- mul_prod  in  2*DATA_WIDTH  unsigned product from multiplier
- stall  out  1  request present but not accepted this cycle
- busy  out  1  multiply in flight
- rd_data  out  DATA_WIDTH  MFHI/MFLO result
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- hi, lo  out  DATA_WIDTH  current HI/LO contents

## Operation
- A request is accepted when op_valid & !stall & !flush.
- stall = op_valid & busy, combinational. Every opcode stalls while busy.
- The FSM has two states, IDLE and CALC.
- IDLE, MULT/MULTU accepted:
  - Latch operand magnitudes into mul_in1/mul_in2. MULTU uses the raw operands. MULT uses |op_a| and |op_b| and latches neg = sign(a)^sign(b).
  - Load cnt = MULT_LATENCY-1 and go to CALC.
- CALC, cnt != 0: decrement cnt.
- CALC, cnt == 0:
  - result = neg ? -mul_prod : mul_prod, computed mod 2^(2*DATA_WIDTH).
  - {hi,lo} <= result, then go to IDLE.
- The most-negative operand (0x80000000) has magnitude 0x80000000 unsigned. The result remains correct.
- MFHI/MFLO (IDLE only): the next clock registers rd_data <= hi/lo and pulses rd_valid.
- MTHI/MTLO (IDLE only): the next clock writes op_a into hi/lo.
- flush in CALC returns the FSM to IDLE. HI/LO are unchanged and no result is written.
- flush in IDLE discards the request.
- flush arriving in the same cycle as the final CALC cycle: flush wins and no write occurs.
- MADD/MADDU are handled per Configuration.

## Timing
- Reset values: hi=0, lo=0, rd_data=0, rd_valid=0, busy=0, mul_in1=0, mul_in2=0, state IDLE, cnt=0, neg=0.
- Reset mid-CALC abandons the multiply with no write.
- For a multiply accepted in cycle T:
  - busy is high in cycles T+1..T+MULT_LATENCY.
  - hi/lo show the new value from cycle T+MULT_LATENCY+1.
- A dependent MFHI presented in cycle T+1 stalls through T+MULT_LATENCY, is accepted in T+MULT_LATENCY+1, and pulses rd_valid in T+MULT_LATENCY+2.
- Back-to-back multiplies: the second is accepted at T+MULT_LATENCY+1, giving zero dead cycles.
- With MULT_LATENCY=1, CALC lasts exactly one cycle.
- mul_in1/mul_in2 hold steady throughout CALC.

## Configuration
- MULDIV_ACCUM_EN defined:
  - MADD/MADDU behave as MULT/MULTU, except the final write is {hi,lo} <= {hi,lo} + result, with 2*DATA_WIDTH wrap-around.
  - The accumulate reads HI/LO as they stand at the final CALC cycle.
- MULDIV_ACCUM_EN undefined:
  - Opcodes 110/111 are accepted as no-ops: no state change and no rd_valid.
  - stall still applies to them while busy.

## Structure
- Shared package muldiv_pkg holds:
  - the op_code localparams (OP_MULT..OP_MADDU)
  - the FSM state typedef (ST_IDLE, ST_CALC)
  - the cnt width constant (4)
- One sub-module, muldiv_signfix, is combinational and contains:
  - operand magnitude and neg generation
  - the product negate mux
  - the MADD accumulate adder when MULDIV_ACCUM_EN is defined
- The multiplier itself is instantiated outside this block. It is connected through mul_in1/mul_in2/mul_prod.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002, MULT_LATENCY=4 -> busy high 4 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
- MULT 0xFFFFFFFF × 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- MFHI issued the cycle after a MULT accept -> stall high 4 cycles, then rd_valid with the new hi. An MTLO 0x1234 in IDLE -> lo=0x1234 next cycle.
- MULT accepted, flush asserted in the 2nd CALC cycle -> busy drops next cycle and hi/lo retain their prior values. Async reset mid-CALC -> all outputs 0.
- With MULDIV_ACCUM_EN: MTHI 0, MTLO 5, then MADDU 3×4 -> lo=17, hi=0. Without it: MADDU leaves hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state type and counter width for the
// HI/LO multiply sequencer (muldiv_seq and muldiv_signfix).
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MFHI  = 3'b010;
  localparam logic [2:0] OP_MFLO  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_CALC
  } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling around the unsigned multiplier.
// Ports: a/b operands, sgn (signed op) -> mag_a/mag_b magnitudes
// and neg; neg_q/acc_q/prod/hilo -> wdata, the final HI/LO value.
// MULDIV_ACCUM_EN adds the MADD/MADDU accumulate adder.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  input  logic           neg_q,
  input  logic           acc_q,
  input  logic [2*W-1:0] prod,
  input  logic [2*W-1:0] hilo,
  output logic [W-1:0]   mag_a,
  output logic [W-1:0]   mag_b,
  output logic           neg,
  output logic [2*W-1:0] wdata
);

  logic           a_neg;
  logic           b_neg;
  logic [2*W-1:0] res;

  assign a_neg = sgn & a[W-1];
  assign b_neg = sgn & b[W-1];

  // -0x80..0 wraps to itself, which is the correct magnitude
  // when read as unsigned.
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;
  assign neg   = a_neg ^ b_neg;

  assign res = neg_q ? -prod : prod;

`ifdef MULDIV_ACCUM_EN
  assign wdata = acc_q ? hilo + res : res;
`else
  logic unused_acc;
  assign unused_acc = ^{acc_q, hilo};
  assign wdata = res;
`endif

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner and multi-cycle sequencer for the shared multiplier.
// Ports: op_valid/op_code/op_a/op_b/flush in; mul_in1/mul_in2 out,
// mul_prod in; stall, busy, rd_data, rd_valid, hi, lo out.
// MULDIV_ACCUM_EN enables MADD/MADDU; otherwise they are no-ops.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    op_valid,
  input  logic [2:0]              op_code,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   mul_in1,
  output logic [DATA_WIDTH-1:0]   mul_in2,
  input  logic [2*DATA_WIDTH-1:0] mul_prod,
  output logic                    stall,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MULT_LATENCY - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    neg_q;
  logic                    acc_q;
  logic                    accept;
  logic                    is_mul;
  logic                    is_sgn;
  logic                    is_acc;
  logic [DATA_WIDTH-1:0]   mag_a;
  logic [DATA_WIDTH-1:0]   mag_b;
  logic                    neg;
  logic [2*DATA_WIDTH-1:0] wdata;

  assign stall  = op_valid & busy;
  assign accept = op_valid & ~stall & ~flush;

  assign is_sgn = (op_code == OP_MULT) |
                  (op_code == OP_MADD);

`ifdef MULDIV_ACCUM_EN
  assign is_acc = (op_code == OP_MADD) |
                  (op_code == OP_MADDU);
`else
  assign is_acc = 1'b0;
`endif

  assign is_mul = (op_code == OP_MULT)  |
                  (op_code == OP_MULTU) |
                  is_acc;

  muldiv_signfix #(
    .W (DATA_WIDTH)
  ) u_signfix (
    .a     (op_a),
    .b     (op_b),
    .sgn   (is_sgn),
    .neg_q (neg_q),
    .acc_q (acc_q),
    .prod  (mul_prod),
    .hilo  ({hi, lo}),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .neg   (neg),
    .wdata (wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= 1'b0;
      busy     <= 1'b0;
      mul_in1  <= '0;
      mul_in2  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mul: begin
                mul_in1 <= mag_a;
                mul_in2 <= mag_b;
                neg_q   <= neg;
                acc_q   <= is_acc;
                cnt     <= CNT_LOAD;
                busy    <= 1'b1;
                state   <= ST_CALC;
              end
              (op_code == OP_MFHI): begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              (op_code == OP_MFLO): begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              (op_code == OP_MTHI): hi <= op_a;
              (op_code == OP_MTLO): lo <= op_a;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            {hi, lo} <= wdata;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random
// operations against a transaction-level HI/LO reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic [W-1:0] mul_in1, mul_in2;
  logic [2*W-1:0] mul_prod;
  logic         stall, busy, rd_valid;
  logic [W-1:0] rd_data, hi, lo;

  int nchecks = 0;
  int nerrors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  // external combinational multiplier
  assign mul_prod = {{W{1'b0}}, mul_in1} * {{W{1'b0}}, mul_in2};

  muldiv_seq #(
    .DATA_WIDTH   (W),
    .MULT_LATENCY (L)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .mul_in1  (mul_in1),
    .mul_in2  (mul_in2),
    .mul_prod (mul_prod),
    .stall    (stall),
    .busy     (busy),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_signed_op(input logic [2:0] op);
    return op == OP_MULT || op == OP_MADD;
  endfunction

  function automatic bit is_mul_op(input logic [2:0] op);
`ifdef MULDIV_ACCUM_EN
    return op == OP_MULT || op == OP_MULTU ||
           op == OP_MADD || op == OP_MADDU;
`else
    return op == OP_MULT || op == OP_MULTU;
`endif
  endfunction

  function automatic logic [63:0] ref_prod(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb;
    if (is_signed_op(op)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [W-1:0] ref_mag(input logic [2:0] op,
                                           input logic [W-1:0] a);
    if (is_signed_op(op) && a[W-1]) return 32'd0 - a;
    return a;
  endfunction

  function automatic logic [63:0] ref_write(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    if (op == OP_MADD || op == OP_MADDU)
      return {m_hi, m_lo} + ref_prod(op, a, b);
    return ref_prod(op, a, b);
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    step();
    op_valid = 1'b0;
  endtask

  // Issue one op in IDLE, follow it to completion and check it.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [63:0] nv;
    issue(op, a, b);
    if (is_mul_op(op)) begin
      chk("mul_in1", 64'(mul_in1), 64'(ref_mag(op, a)));
      chk("mul_in2", 64'(mul_in2), 64'(ref_mag(op, b)));
      for (int i = 0; i < L; i++) begin
        chk("busy_calc", 64'(busy), 64'd1);
        step();
      end
      nv = ref_write(op, a, b);
      m_hi = nv[63:32];
      m_lo = nv[31:0];
      chk("busy_done", 64'(busy), 64'd0);
      chk("hi_mul", 64'(hi), 64'(m_hi));
      chk("lo_mul", 64'(lo), 64'(m_lo));
    end else if (op == OP_MFHI || op == OP_MFLO) begin
      chk("rd_valid", 64'(rd_valid), 64'd1);
      chk("rd_data", 64'(rd_data),
          64'((op == OP_MFHI) ? m_hi : m_lo));
      step();
      chk("rd_valid_pulse", 64'(rd_valid), 64'd0);
    end else begin
      if (op == OP_MTHI) m_hi = a;
      if (op == OP_MTLO) m_lo = a;
      chk("hi_mt", 64'(hi), 64'(m_hi));
      chk("lo_mt", 64'(lo), 64'(m_lo));
      chk("rd_valid_none", 64'(rd_valid), 64'd0);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] corner [4];
    corner[0] = 32'h8000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h0000_0000;
    corner[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    #12;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_in", 64'({mul_in1, mul_in2}), 64'd0);
    rst_n = 1'b1;
    step();

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("multu_const", 64'({hi, lo}), 64'h0000_0001_FFFF_FFFE);

    do_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("mult_neg_const", 64'({hi, lo}), 64'hFFFF_FFFF_FFFF_FFFE);

    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    chk("mult_minmin", 64'({hi, lo}), 64'h4000_0000_0000_0000);

    // Dependent MFHI right behind a MULT: 7 * -3 = -21
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    op_valid = 1'b1;
    op_code  = OP_MFHI;
    for (int i = 0; i < L; i++) begin
      chk("dep_stall", 64'(stall), 64'd1);
      step();
    end
    chk("dep_stall_off", 64'(stall), 64'd0);
    step();
    op_valid = 1'b0;
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFEB;
    chk("dep_rd_valid", 64'(rd_valid), 64'd1);
    chk("dep_rd_data", 64'(rd_data), 64'(m_hi));
    chk("dep_lo", 64'(lo), 64'(m_lo));
    step();

    do_op(OP_MTLO, 32'h0000_1234, 32'd0);
    chk("mtlo_const", 64'(lo), 64'h1234);

    // Back-to-back multiplies: second accepted at T+L+1
    issue(OP_MULTU, 32'd10, 32'd20);
    op_valid = 1'b1;
    op_code  = OP_MULTU;
    op_a     = 32'd3;
    op_b     = 32'd5;
    for (int i = 0; i < L; i++) step();
    chk("b2b_first", 64'({hi, lo}), 64'd200);
    chk("b2b_stall_off", 64'(stall), 64'd0);
    step();
    op_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      chk("b2b_busy", 64'(busy), 64'd1);
      step();
    end
    chk("b2b_second", 64'({hi, lo}), 64'd15);
    m_hi = 32'd0;
    m_lo = 32'd15;

    // Flush in 2nd CALC cycle
    issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hilo", 64'({hi, lo}), 64'({m_hi, m_lo}));
    for (int i = 0; i < L; i++) step();
    chk("flush_hilo_late", 64'({hi, lo}), 64'({m_hi, m_lo}));

    // Flush on the final CALC cycle: no write
    issue(OP_MULTU, 32'd99, 32'd99);
    for (int i = 0; i < L - 1; i++) step();
    chk("fin_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fin_flush_busy", 64'(busy), 64'd0);
    chk("fin_flush_hilo", 64'({hi, lo}), 64'({m_hi, m_lo}));

    // Flush in IDLE discards the request
    op_valid = 1'b1;
    op_code  = OP_MTHI;
    op_a     = 32'hDEAD_BEEF;
    flush    = 1'b1;
    step();
    op_valid = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_hi", 64'(hi), 64'(m_hi));

    // Accumulate
    do_op(OP_MTHI, 32'd0, 32'd0);
    do_op(OP_MTLO, 32'd5, 32'd0);
    do_op(OP_MADDU, 32'd3, 32'd4);
`ifdef MULDIV_ACCUM_EN
    chk("maddu_const", 64'({hi, lo}), 64'd17);
`else
    chk("maddu_const", 64'({hi, lo}), 64'd5);
`endif

    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end

    // Async reset mid-CALC
    issue(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0003);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hilo", 64'({hi, lo}), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mul_in", 64'({mul_in1, mul_in2}), 64'd0);
    chk("arst_rd", 64'({rd_valid, rd_data}), 64'd0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < L + 1; i++) step();
    chk("arst_no_write", 64'({hi, lo}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
